var_delay_line: RTL and testbench

- Runtime-programmable, clock-enable-gated delay line for pixel streams.
- Aligns left/right camera pixel streams before the disparity cost stage, when the two paths differ in latency.
- It is the read side of a circular buffer. Output is the sample written D accepted samples earlier, not D clocks earlier.
- Used where a fixed single-stage `delay` register cannot absorb the latency skew.

---
 rtl/var_delay_line_if.sv | 26 ++
 rtl/var_delay_line.sv | 113 +++++++++++
 tb/tb_var_delay_line.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/var_delay_line_if.sv
// Pixel-stream bus for the variable delay line: sample in, delay request, delayed sample out.
// Latency: none, this is signal grouping only.
// Backpressure: none; the producer gates samples with ce and the consumer must take every ovalid.
interface var_delay_line_if #(
   parameter int N  = 8,
   parameter int AW = 4
);
   logic          ce;
   logic [N-1:0]  idata;
   logic [AW:0]   delay_cfg;
   logic [N-1:0]  odata;
   logic          ovalid;
   logic          primed;

   // Producer side: drives samples and the delay request, observes the delayed stream.
   modport master (
      output ce, idata, delay_cfg,
      input  odata, ovalid, primed
   );

   // Delay line side.
   modport slave (
      input  ce, idata, delay_cfg,
      output odata, ovalid, primed
   );
endinterface

// File: rtl/var_delay_line.sv
// Runtime-programmable circular-buffer delay line: odata is the sample accepted D samples earlier.
// Latency: one clk after the accepting ce edge; ce gaps stretch time, not sample alignment.
// Backpressure: none; one sample is taken on every ce=1 clk, ovalid is a one-clk strobe.
module var_delay_line #(
   parameter  int N     = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   var_delay_line_if.slave bus
);

   typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = (AW+1)'(1);

   logic [N-1:0]  mem_q [DEPTH];

   state_t        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   fill_q, fill_d;
   logic [AW:0]   cur_q, cur_d;
   logic [N-1:0]  odata_q, odata_d;
   logic          ovalid_q, ovalid_d;

   logic [AW:0]   eff_dly;
   logic [AW:0]   fill_inc;
   logic [AW-1:0] rd_idx;

   // Clamp the requested delay into the legal 1..DEPTH range.
   always_comb begin
      eff_dly = bus.delay_cfg;
      if (bus.delay_cfg == '0) begin
         eff_dly = ONE_W;
      end else if (bus.delay_cfg > DEPTH_W) begin
         eff_dly = DEPTH_W;
      end
   end

   // Read slot is cur_q samples behind the write slot; with cur_q=DEPTH the low bits are zero,
   // so the read lands on the word about to be overwritten and returns its old contents.
   assign rd_idx   = wptr_q - cur_q[AW-1:0];
   assign fill_inc = fill_q + (bus.ce ? ONE_W : '0);

   // Next-state logic: delay change overrides everything, else FILL counts and RUN emits.
   always_comb begin
      state_d  = state_q;
      wptr_d   = bus.ce ? wptr_q + 1'b1 : wptr_q;
      fill_d   = fill_q;
      cur_d    = cur_q;
      odata_d  = odata_q;
      ovalid_d = 1'b0;
      if (eff_dly != cur_q) begin
         // Restart the fill against the new delay; a sample taken now is the first one.
         cur_d   = eff_dly;
         state_d = FILL;
         fill_d  = bus.ce ? ONE_W : '0;
      end else begin
         case (state_q)
            FILL: begin
               // Saturate at cur_q so the counter can never wrap; a fill already complete
               // (e.g. a change to D=1 with a sample) promotes on the next clk without ce.
               if (fill_inc >= cur_q) begin
                  fill_d  = cur_q;
                  state_d = RUN;
               end else begin
                  fill_d  = fill_inc;
               end
            end
            RUN: begin
               if (bus.ce) begin
                  odata_d  = mem_q[rd_idx];
                  ovalid_d = 1'b1;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FILL;
         wptr_q   <= '0;
         fill_q   <= '0;
         cur_q    <= ONE_W;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         fill_q   <= fill_d;
         cur_q    <= cur_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
      end
   end

   // Sample storage; contents are don't-care after reset, so no reset term.
   always_ff @(posedge clk) begin
      if (bus.ce) begin
         mem_q[wptr_q] <= bus.idata;
      end
   end

   assign bus.odata  = odata_q;
   assign bus.ovalid = ovalid_q;
   assign bus.primed = (state_q == RUN);

endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line with a queue-based sample-history model checked every cycle.
// Latency: outputs sampled on the falling edge, one half-cycle after the edge that produced them.
// Backpressure: none; stimulus is driven on the falling edge with blocking assignments.
module tb_var_delay_line;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   var_delay_line_if #(.N(8), .AW(4)) bus ();

   var_delay_line #(.N(8), .DEPTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: every accepted sample is appended to hist; the expected output is simply
   // the entry cur samples back from the end, once cur samples have arrived since the
   // last reset or delay change.
   logic [7:0] hist[$];
   logic [7:0] outs[$];
   int         m_cur;
   int         m_fill;
   bit         m_run;
   logic [7:0] m_odata;
   bit         m_valid;

   function automatic int clamp(input int c);
      if (c == 0) return 1;
      if (c > 16) return 16;
      return c;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour, advanced on each rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cur   = 1;
         m_fill  = 0;
         m_run   = 0;
         m_odata = 8'h00;
         m_valid = 0;
         hist.delete();
      end else begin
         int eff;
         eff = clamp(int'(bus.delay_cfg));
         m_valid = 0;
         if (eff != m_cur) begin
            m_cur  = eff;
            m_run  = 0;
            m_fill = bus.ce ? 1 : 0;
         end else if (!m_run) begin
            if (bus.ce) m_fill++;
            if (m_fill >= m_cur) m_run = 1;
         end else if (bus.ce) begin
            m_odata = hist[hist.size() - m_cur];
            m_valid = 1;
         end
         if (bus.ce) hist.push_back(bus.idata);
      end
   end

   // Cycle-by-cycle compare against the model, and capture of the delivered stream.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("ovalid", 32'(bus.ovalid), 32'(m_valid));
         chk("primed", 32'(bus.primed), 32'(m_run));
         chk("odata",  32'(bus.odata),  32'(m_odata));
         if (bus.ovalid) outs.push_back(bus.odata);
      end
   end

   task automatic step(input logic c, input logic [7:0] d);
      @(negedge clk);
      bus.ce    = c;
      bus.idata = d;
   endtask

   task automatic do_reset(input logic [4:0] cfg);
      @(negedge clk);
      bus.ce        = 1'b0;
      bus.idata     = 8'h00;
      bus.delay_cfg = cfg;
      rst_n         = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      outs.delete();
   endtask

   task automatic drain();
      step(1'b0, 8'h00);
      step(1'b0, 8'h00);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      bus.ce = 1'b0;
      bus.idata = 8'h00;
      bus.delay_cfg = 5'd3;
      #12;
      chk("reset_odata",  32'(bus.odata),  32'h0);
      chk("reset_ovalid", 32'(bus.ovalid), 32'h0);
      chk("reset_primed", 32'(bus.primed), 32'h0);

      // D=3, five consecutive samples.
      do_reset(5'd3);
      step(1'b1, 8'h10);
      step(1'b1, 8'h11);
      step(1'b1, 8'h12);
      chk("t1_primed_after2", 32'(bus.primed), 32'h0);
      step(1'b1, 8'h13);
      chk("t1_primed_after3", 32'(bus.primed), 32'h1);
      chk("t1_noval_after3",  32'(bus.ovalid), 32'h0);
      step(1'b1, 8'h14);
      drain();
      chk("t1_count", 32'(outs.size()), 32'd2);
      if (outs.size() == 2) begin
         chk("t1_out0", 32'(outs[0]), 32'h10);
         chk("t1_out1", 32'(outs[1]), 32'h11);
      end

      // D=3 with ce gaps: accepted samples 0..5, outputs 0..2.
      do_reset(5'd3);
      begin
         bit pat[10] = '{1, 0, 0, 1, 1, 0, 1, 1, 0, 1};
         logic [7:0] v;
         v = 8'h00;
         foreach (pat[i]) begin
            step(pat[i], v);
            if (pat[i]) v++;
         end
      end
      drain();
      chk("t2_count", 32'(outs.size()), 32'd3);
      if (outs.size() == 3) begin
         chk("t2_out0", 32'(outs[0]), 32'h00);
         chk("t2_out2", 32'(outs[2]), 32'h02);
      end

      // D=DEPTH across pointer wrap.
      do_reset(5'd16);
      for (int i = 0; i < 40; i++) step(1'b1, 8'(i));
      drain();
      chk("t3_count", 32'(outs.size()), 32'd24);
      for (int i = 0; i < outs.size(); i++) chk("t3_seq", 32'(outs[i]), 32'(i));

      // Delay change 4 -> 2 in a cycle that also accepts a sample.
      do_reset(5'd4);
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i));
      drain();
      chk("t4_pre_count", 32'(outs.size()), 32'd4);
      if (outs.size() == 4) chk("t4_pre_last", 32'(outs[3]), 32'h43);
      outs.delete();
      step(1'b1, 8'h48);
      bus.delay_cfg = 5'd2;
      step(1'b1, 8'h49);
      chk("t4_chg_ovalid", 32'(bus.ovalid), 32'h0);
      chk("t4_chg_primed", 32'(bus.primed), 32'h0);
      step(1'b1, 8'h4A);
      chk("t4_refill_primed", 32'(bus.primed), 32'h1);
      chk("t4_refill_ovalid", 32'(bus.ovalid), 32'h0);
      step(1'b0, 8'h00);
      chk("t4_first_ovalid", 32'(bus.ovalid), 32'h1);
      chk("t4_first_odata",  32'(bus.odata),  32'h48);
      step(1'b0, 8'h00);

      // delay_cfg=0 behaves as D=1.
      do_reset(5'd0);
      step(1'b1, 8'h50);
      step(1'b1, 8'h51);
      step(1'b1, 8'h52);
      drain();
      chk("t5a_count", 32'(outs.size()), 32'd2);
      if (outs.size() == 2) begin
         chk("t5a_out0", 32'(outs[0]), 32'h50);
         chk("t5a_out1", 32'(outs[1]), 32'h51);
      end

      // delay_cfg=31 behaves as D=16.
      do_reset(5'd31);
      for (int i = 0; i < 20; i++) step(1'b1, 8'(i));
      drain();
      chk("t5b_count", 32'(outs.size()), 32'd4);
      if (outs.size() == 4) begin
         chk("t5b_out0", 32'(outs[0]), 32'h00);
         chk("t5b_out3", 32'(outs[3]), 32'h03);
      end

      // Asynchronous reset between edges, mid-stream.
      do_reset(5'd3);
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h60 + i));
      chk("t6_pre_ovalid", 32'(bus.ovalid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_arst_odata",  32'(bus.odata),  32'h0);
      chk("t6_arst_ovalid", 32'(bus.ovalid), 32'h0);
      chk("t6_arst_primed", 32'(bus.primed), 32'h0);
      bus.ce = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      outs.delete();
      for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h70 + i));
      drain();
      chk("t6_count", 32'(outs.size()), 32'd3);
      if (outs.size() == 3) begin
         chk("t6_out0", 32'(outs[0]), 32'h70);
         chk("t6_out2", 32'(outs[2]), 32'h72);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
